// File: rtl/tx_port_scheduler_if.sv
// Queue-side and lane-side signals of one output port scheduler.
// master: the scheduler; slave: the source queues and transmit lane it talks to.
interface tx_port_scheduler_if #(
    parameter int unsigned P_NUM_SRC = 4
) ();
    logic [P_NUM_SRC-1:0]   frame_rdy_i;
    logic [9*P_NUM_SRC-1:0] q_data_i;
    logic [P_NUM_SRC-1:0]   rd_o;
    logic [7:0]             tx_data_o;
    logic                   tx_ctrl_o;

    modport master (
        input  frame_rdy_i,
        input  q_data_i,
        output rd_o,
        output tx_data_o,
        output tx_ctrl_o
    );

    modport slave (
        output frame_rdy_i,
        output q_data_i,
        input  rd_o,
        input  tx_data_o,
        input  tx_ctrl_o
    );
endinterface

// File: rtl/tx_port_scheduler.sv
// Per-lane frame scheduler: round-robin over source queues one frame at a time,
// with inter-frame gap, max-length truncation and link-loss truncation.
module tx_port_scheduler #(
    parameter int unsigned P_NUM_SRC   = 4,
    parameter int unsigned P_IFG       = 12,
    parameter int unsigned P_MAX_FRAME = 1522,
    parameter int unsigned P_LEN_WIDTH = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  link_up_i,
    tx_port_scheduler_if.master   q_if,
    output logic [P_NUM_SRC-1:0]  grant_o,
    output logic                  busy_o,
    output logic [15:0]           frames_sent_o,
    output logic [15:0]           frames_trunc_o
);
    localparam int unsigned PtrW = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StDrain, StGap} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [P_NUM_SRC-1:0]   grant_q, grant_d;
    logic [P_LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]            gap_cnt_q, gap_cnt_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_ctrl_q, tx_ctrl_d;
    logic [15:0]            sent_q, sent_d;
    logic [15:0]            trunc_q, trunc_d;

    logic [P_NUM_SRC-1:0]   req;
    logic                   win_found;
    logic [PtrW-1:0]        win_idx;
    logic [PtrW-1:0]        cand;
    logic [8:0]             head;

    assign req = q_if.frame_rdy_i & {P_NUM_SRC{link_up_i}};

    // Search starts just after the last winner so fairness is per frame.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= P_NUM_SRC; k++) begin
            cand = PtrW'((32'(ptr_q) + k) % P_NUM_SRC);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ptr_q always holds the current owner, so it doubles as the head-word mux select.
    always_comb begin
        head = '0;
        for (int unsigned i = 0; i < P_NUM_SRC; i++) begin
            if (ptr_q == PtrW'(i)) head = q_if.q_data_i[9*i +: 9];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_data_d  = '0;
        tx_ctrl_d  = 1'b0;
        sent_d     = sent_q;
        trunc_d    = trunc_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d    = P_NUM_SRC'(1) << win_idx;
                    ptr_d      = win_idx;
                    byte_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                tx_data_d  = head[7:0];
                tx_ctrl_d  = 1'b1;
                byte_cnt_d = byte_cnt_q + P_LEN_WIDTH'(1);
                if (head[8]) begin
                    sent_d    = sent_q + {15'd0, sent_q != 16'hFFFF};
                    grant_d   = '0;
                    gap_cnt_d = 16'd1;
                    state_d   = StGap;
                end else if (!link_up_i || byte_cnt_q == P_LEN_WIDTH'(P_MAX_FRAME - 1)) begin
                    trunc_d = trunc_q + {15'd0, trunc_q != 16'hFFFF};
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (head[8]) begin
                    grant_d   = '0;
                    gap_cnt_d = 16'd1;
                    state_d   = StGap;
                end
            end
            StGap: begin
                // The pop cycle of the last word counts as gap cycle 0.
                if (gap_cnt_q >= 16'(P_IFG - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            ptr_q      <= PtrW'(P_NUM_SRC - 1);
            grant_q    <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_data_q  <= '0;
            tx_ctrl_q  <= 1'b0;
            sent_q     <= '0;
            trunc_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_ctrl_q  <= tx_ctrl_d;
            sent_q     <= sent_d;
            trunc_q    <= trunc_d;
        end
    end

    assign q_if.rd_o      = (state_q == StSend || state_q == StDrain) ? grant_q : '0;
    assign q_if.tx_data_o = tx_data_q;
    assign q_if.tx_ctrl_o = tx_ctrl_q;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q != StIdle);
    assign frames_sent_o  = sent_q;
    assign frames_trunc_o = trunc_q;

endmodule

// File: tb/tb_tx_port_scheduler.sv
// Bench for tx_port_scheduler: queue models feed random frames; a frame-level
// model predicts grant order, transmitted bytes, gaps and counters.
module tb_tx_port_scheduler;
    localparam int unsigned N    = 4;
    localparam int unsigned IFG  = 12;
    localparam int unsigned MAXF = 1522;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_up;
    logic [N-1:0]  grant;
    logic          busy;
    logic [15:0]   sent;
    logic [15:0]   trunc;

    tx_port_scheduler_if #(.P_NUM_SRC(N)) q_if ();

    tx_port_scheduler #(
        .P_NUM_SRC  (N),
        .P_IFG      (IFG),
        .P_MAX_FRAME(MAXF),
        .P_LEN_WIDTH(11)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .link_up_i     (link_up),
        .q_if          (q_if),
        .grant_o       (grant),
        .busy_o        (busy),
        .frames_sent_o (sent),
        .frames_trunc_o(trunc)
    );

    always #5 clk = ~clk;

    // Source queue contents as the DUT sees them
    logic [8:0] srcq   [N][$];
    int         nlast  [N];
    logic [N-1:0] pend_rd;
    // Frame-level reference model
    logic [7:0] mbytes [N][$];
    int         mlens  [N][$];
    int         mptr;
    logic [7:0] cur [$];
    int         pos, exp_n, idle_run, link_cut;
    bit         in_burst, gap_check, cur_trunc;
    logic [N-1:0] prev_grant;
    int         exp_sent, exp_trunc;
    int         checks, failures;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (mlens[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick();
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (mptr + k) % N;
            if (mlens[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            q_if.q_data_i[9*i +: 9] = (srcq[i].size() > 0) ? srcq[i][0] : 9'd0;
            q_if.frame_rdy_i[i]     = (nlast[i] > 0);
        end
    endtask

    task automatic enqueue(int src, int len);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            srcq[src].push_back({(k == len - 1), b});
            mbytes[src].push_back(b);
        end
        nlast[src]++;
        mlens[src].push_back(len);
        drive();
    endtask

    task automatic monitor();
        int w, len;
        check("rd_eq_grant", q_if.rd_o, grant);
        if (grant != 0 && prev_grant == 0) begin
            w = pick();
            if (w < 0) begin
                check("unexpected_grant", grant, 0);
            end else begin
                check("grant_order", grant, 32'(1) << w);
                len = mlens[w].pop_front();
                cur.delete();
                for (int k = 0; k < len; k++) cur.push_back(mbytes[w].pop_front());
                exp_n = (len > int'(MAXF)) ? int'(MAXF) : len;
                if (link_cut > 0 && link_cut < exp_n) exp_n = link_cut;
                cur_trunc = (exp_n < len);
                if (cur_trunc) exp_trunc++; else exp_sent++;
                pos  = 0;
                mptr = w;
            end
        end
        prev_grant = grant;
        if (q_if.tx_ctrl_o) begin
            if (!in_burst) begin
                if (gap_check) check("ifg_len", idle_run, IFG);
                in_burst = 1'b1;
            end
            if (pos < exp_n) check("tx_byte", q_if.tx_data_o, cur[pos]);
            else check("extra_byte", pos, exp_n);
            pos++;
        end else begin
            check("idle_data_zero", q_if.tx_data_o, 0);
            if (in_burst) begin
                in_burst = 1'b0;
                check("burst_len", pos, exp_n);
                idle_run  = 1;
                gap_check = !cur_trunc && pending();
            end else begin
                idle_run++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (pend_rd[i] && srcq[i].size() > 0) begin
                if (srcq[i][0][8]) nlast[i]--;
                void'(srcq[i].pop_front());
            end
        end
        drive();
        monitor();
        pend_rd = q_if.rd_o;
    endtask

    task automatic run_until_done(int max_cycles);
        int n = 0;
        while ((pending() || busy || in_burst) && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_timeout", (n < max_cycles), 1);
    endtask

    task automatic check_counters(string tag);
        check({tag, "_sent"}, sent, exp_sent);
        check({tag, "_trunc"}, trunc, exp_trunc);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mbytes[i].delete();
            mlens[i].delete();
            nlast[i] = 0;
        end
        cur.delete();
        pend_rd    = '0;
        mptr       = N - 1;
        pos        = 0;
        exp_n      = 0;
        idle_run   = 0;
        link_cut   = 0;
        in_burst   = 1'b0;
        gap_check  = 1'b0;
        cur_trunc  = 1'b0;
        prev_grant = '0;
        exp_sent   = 0;
        exp_trunc  = 0;
        drive();
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        link_up  = 1'b1;
        clear_model();
        #1;
        check("rst_rd", q_if.rd_o, 0);
        check("rst_tx_ctrl", q_if.tx_ctrl_o, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single source 2, 64-byte frame: pop next cycle, first byte the cycle after.
        enqueue(2, 64);
        tick();
        check("lat_rd", q_if.rd_o, 4'b0100);
        tick();
        check("lat_tx_ctrl", q_if.tx_ctrl_o, 1);
        run_until_done(300);
        check_counters("single");

        // All four sources, two 8-byte frames each: rotation and exact gaps.
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) enqueue(s, 8);
        run_until_done(400);
        check_counters("rr");

        // Over-length frame truncated, then a short frame on the same queue.
        enqueue(1, 1600);
        enqueue(1, 5);
        run_until_done(2000);
        check_counters("overlen");

        // Exactly max length: last flag wins over truncation.
        enqueue(0, MAXF);
        run_until_done(1700);
        check_counters("exactmax");

        // Link lost while the 10th byte is popped: 10 bytes out, 30 drained.
        link_cut = 10;
        enqueue(3, 40);
        n = 0;
        while (!(in_burst && pos >= 9) && n < 100) begin
            tick();
            n++;
        end
        check("link_wait_timeout", (n < 100), 1);
        link_up = 1'b0;
        run_until_done(200);
        link_cut = 0;
        check_counters("linkdrop");
        enqueue(0, 6);
        for (int k = 0; k < 20; k++) tick();
        check("linkdown_grant", grant, 0);
        check("linkdown_busy", busy, 0);
        link_up = 1'b1;
        run_until_done(200);
        check_counters("linkup");

        // Random frames on random sources.
        for (int f = 0; f < 16; f++) enqueue($urandom_range(N - 1, 0), $urandom_range(60, 1));
        run_until_done(3000);
        check_counters("random");

        // Reset in the middle of a frame takes effect without a clock edge.
        enqueue(3, 200);
        n = 0;
        while (!(in_burst && pos >= 5) && n < 400) begin
            tick();
            n++;
        end
        check("rst_wait_timeout", (n < 400), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd", q_if.rd_o, 0);
        check("midrst_tx_ctrl", q_if.tx_ctrl_o, 0);
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        clear_model();
        check_counters("midrst");
        #1 rst_n = 1'b1;
        for (int s = N - 1; s >= 0; s--) enqueue(s, 8);
        tick();
        check("post_rst_first", grant, 4'b0001);
        run_until_done(400);
        check_counters("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
